// File: rtl/intc_err_pkg.sv
// Shared types and sizes for the error-interrupt request/acknowledge path.
package intc_err_pkg;

    localparam int NUM_ERR  = 8;
    localparam int ERR_ID_W = 3;
    localparam int CNT_W    = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        SRV  = 2'd2
    } err_state_e;

endpackage

// File: rtl/intc_err_prio.sv
// Lowest-index-wins priority encoder; valid is high when any request bit is set.
module intc_err_prio
    import intc_err_pkg::*;
(
    input  logic [NUM_ERR-1:0]  req,
    output logic [ERR_ID_W-1:0] id,
    output logic                valid
);

    always_comb begin
        id    = '0;
        valid = |req;
        // Scan downwards so the lowest set index is the last assignment.
        for (int i = NUM_ERR - 1; i >= 0; i--) begin
            if (req[i]) begin
                id = ERR_ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intc_err_req.sv
// Error-interrupt sequencer: picks the highest-priority pending source, requests the CPU,
// and turns CPU acceptance into a one-cycle acknowledge pulse for the capture stage.
module intc_err_req
    import intc_err_pkg::*;
#(
    parameter logic [7:0] VEC_BASE  = 8'h40,
    parameter logic [3:0] ERR_LEVEL = 4'hF,
    parameter int         ACK_TMO   = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_intreq_err_i,
    input  logic [NUM_ERR-1:0]  in_eirq_i,
    output logic                cpu_intreq_o,
    output logic [3:0]          cpu_level_o,
    output logic [7:0]          cpu_vec_o,
    input  logic                cpu_ack_i,
    output logic                cp_intack_err_o,
    output logic                err_srv_o,
    output logic [ERR_ID_W-1:0] err_srv_id_o,
    output logic                tmo_o,
    input  logic                tmo_clr_i
);

    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(ACK_TMO - 1);

    err_state_e          state_reg, state_next;
    logic [ERR_ID_W-1:0] id_reg, id_next;
    logic [CNT_W-1:0]    cnt_reg, cnt_next;
    logic                pulse_next;
    logic                tmo_set;
    logic [ERR_ID_W-1:0] arb_id;
    logic                arb_valid;
    logic                id_pending;

    intc_err_prio u_prio (
        .req   (in_eirq_i),
        .id    (arb_id),
        .valid (arb_valid)
    );

    assign id_pending = in_eirq_i[id_reg];

    always_comb begin
        state_next = state_reg;
        id_next    = id_reg;
        cnt_next   = cnt_reg;
        pulse_next = 1'b0;
        tmo_set    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (in_intreq_err_i && arb_valid) begin
                    state_next = REQ;
                    id_next    = arb_id;
                    cnt_next   = '0;
                end
            end
            REQ: begin
                // Counter stops at ACK_TMO at most, so it never wraps.
                cnt_next = cnt_reg + 1'b1;
                if (cpu_ack_i) begin
                    state_next = SRV;
                    pulse_next = 1'b1;
                end else if (!id_pending) begin
                    state_next = IDLE;
                end else if (cnt_reg == TMO_LAST) begin
                    state_next = IDLE;
                    tmo_set    = 1'b1;
                end
            end
            SRV: begin
                if (!id_pending) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            id_reg    <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            id_reg    <= id_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Outputs are registered from the next-state decode so they align with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_intreq_o    <= 1'b0;
            cpu_level_o     <= '0;
            cpu_vec_o       <= '0;
            cp_intack_err_o <= 1'b0;
            err_srv_o       <= 1'b0;
            err_srv_id_o    <= '0;
            tmo_o           <= 1'b0;
        end else begin
            cpu_intreq_o    <= (state_next == REQ);
            cpu_level_o     <= (state_next == REQ) ? ERR_LEVEL : 4'h0;
            cpu_vec_o       <= (state_next == REQ) ? VEC_BASE + {5'b0, id_next} : 8'h00;
            cp_intack_err_o <= pulse_next;
            err_srv_o       <= (state_next == SRV);
            err_srv_id_o    <= id_next;
            if (tmo_set) begin
                tmo_o <= 1'b1;
            end else if (tmo_clr_i) begin
                tmo_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_intc_err_req.sv
// Bench for intc_err_req: directed scenarios with literal expectations, then randomized traffic
// compared every cycle against a transaction-level model.
module tb_intc_err_req;

    localparam int TMO = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_intreq_err_i = 1'b0;
    logic [7:0] in_eirq_i = 8'h00;
    logic       cpu_ack_i = 1'b0;
    logic       tmo_clr_i = 1'b0;
    logic       cpu_intreq_o;
    logic [3:0] cpu_level_o;
    logic [7:0] cpu_vec_o;
    logic       cp_intack_err_o;
    logic       err_srv_o;
    logic [2:0] err_srv_id_o;
    logic       tmo_o;

    int checks = 0;
    int errors = 0;

    // Model: what the sequencer is doing, in plain terms.
    bit m_requesting, m_serving, m_tmo, m_pulse;
    int m_wait, m_id;

    intc_err_req #(.VEC_BASE(8'h40), .ERR_LEVEL(4'hF), .ACK_TMO(TMO)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_intreq_err_i (in_intreq_err_i),
        .in_eirq_i       (in_eirq_i),
        .cpu_intreq_o    (cpu_intreq_o),
        .cpu_level_o     (cpu_level_o),
        .cpu_vec_o       (cpu_vec_o),
        .cpu_ack_i       (cpu_ack_i),
        .cp_intack_err_o (cp_intack_err_o),
        .err_srv_o       (err_srv_o),
        .err_srv_id_o    (err_srv_id_o),
        .tmo_o           (tmo_o),
        .tmo_clr_i       (tmo_clr_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_requesting = 0;
        m_serving    = 0;
        m_tmo        = 0;
        m_pulse      = 0;
        m_wait       = 0;
        m_id         = 0;
    endtask

    task automatic model_step();
        bit timed_out;
        timed_out = 0;
        m_pulse   = 0;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_serving) begin
            if (!in_eirq_i[m_id]) m_serving = 0;
        end else if (m_requesting) begin
            if (cpu_ack_i) begin
                m_requesting = 0;
                m_serving    = 1;
                m_pulse      = 1;
            end else if (!in_eirq_i[m_id]) begin
                m_requesting = 0;
            end else if (m_wait == TMO - 1) begin
                m_requesting = 0;
                timed_out    = 1;
            end else begin
                m_wait++;
            end
        end else if (in_intreq_err_i && in_eirq_i != 0) begin
            for (int i = 7; i >= 0; i--) if (in_eirq_i[i]) m_id = i;
            m_requesting = 1;
            m_wait       = 0;
        end
        if (timed_out) m_tmo = 1;
        else if (tmo_clr_i) m_tmo = 0;
    endtask

    task automatic check_all();
        chk("intreq", cpu_intreq_o, m_requesting);
        if (m_requesting) begin
            chk("level", cpu_level_o, 4'hF);
            chk("vec", cpu_vec_o, (32'h40 + m_id) & 32'hFF);
        end
        chk("ack_pulse", cp_intack_err_o, m_pulse);
        chk("srv", err_srv_o, m_serving);
        chk("srv_id", err_srv_id_o, m_id);
        chk("tmo", tmo_o, m_tmo);
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    initial begin
        int hi_cnt;
        model_reset();
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("rst_intreq", cpu_intreq_o, 0);
        chk("rst_vec", cpu_vec_o, 0);
        chk("rst_level", cpu_level_o, 0);
        chk("rst_srv", err_srv_o, 0);
        chk("rst_tmo", tmo_o, 0);
        step();
        rst_n = 1'b1;

        // Single source
        in_eirq_i = 8'h10; in_intreq_err_i = 1;
        step();
        chk("single_intreq", cpu_intreq_o, 1);
        chk("single_vec", cpu_vec_o, 8'h44);
        chk("single_level", cpu_level_o, 4'hF);
        cpu_ack_i = 1;
        step();
        chk("single_pulse", cp_intack_err_o, 1);
        chk("single_srv_id", err_srv_id_o, 4);
        chk("single_ack_drop", cpu_intreq_o, 0);
        cpu_ack_i = 0;
        step();
        chk("single_pulse_once", cp_intack_err_o, 0);
        chk("single_srv_hold", err_srv_o, 1);
        in_eirq_i = 8'h00; in_intreq_err_i = 0;
        step();
        chk("single_srv_exit", err_srv_o, 0);
        step();

        // Priority and no preemption, then withdraw
        in_eirq_i = 8'hA4; in_intreq_err_i = 1;
        step();
        chk("prio_id", err_srv_id_o, 2);
        chk("prio_vec", cpu_vec_o, 8'h42);
        in_eirq_i = 8'hA5;
        step();
        chk("prio_nopreempt", cpu_vec_o, 8'h42);
        in_eirq_i = 8'hA1;
        step();
        chk("withdraw_intreq", cpu_intreq_o, 0);
        chk("withdraw_pulse", cp_intack_err_o, 0);
        chk("withdraw_tmo", tmo_o, 0);
        in_eirq_i = 8'h00; in_intreq_err_i = 0;
        step();

        // Timeout
        in_eirq_i = 8'h08; in_intreq_err_i = 1;
        hi_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (cpu_intreq_o) hi_cnt++;
            else if (hi_cnt != 0) break;
        end
        chk("tmo_req_cycles", hi_cnt, 4);
        chk("tmo_set", tmo_o, 1);
        in_eirq_i = 8'h00; in_intreq_err_i = 0; tmo_clr_i = 1;
        step();
        chk("tmo_clear", tmo_o, 0);
        tmo_clr_i = 0;

        // Ack on the timeout cycle
        in_eirq_i = 8'h01; in_intreq_err_i = 1;
        step(); step(); step(); step();
        cpu_ack_i = 1;
        step();
        chk("ack_at_tmo_pulse", cp_intack_err_o, 1);
        chk("ack_at_tmo_tmo", tmo_o, 0);
        cpu_ack_i = 0; in_eirq_i = 8'h00; in_intreq_err_i = 0;
        step();
        chk("ack_at_tmo_exit", err_srv_o, 0);

        // Ack and clear together
        in_eirq_i = 8'h02; in_intreq_err_i = 1;
        step();
        cpu_ack_i = 1; in_eirq_i = 8'h00;
        step();
        chk("ack_clr_pulse", cp_intack_err_o, 1);
        chk("ack_clr_srv", err_srv_o, 1);
        cpu_ack_i = 0; in_intreq_err_i = 0;
        step();
        chk("ack_clr_exit", err_srv_o, 0);

        // Asynchronous reset during REQ
        in_eirq_i = 8'h80; in_intreq_err_i = 1;
        step();
        chk("pre_rst_intreq", cpu_intreq_o, 1);
        #2 rst_n = 0;
        model_reset();
        #1 chk("async_rst_intreq", cpu_intreq_o, 0);
        check_all();
        step();
        in_eirq_i = 8'h00; in_intreq_err_i = 0;
        rst_n = 1;
        step();
        chk("post_rst_pulse", cp_intack_err_o, 0);
        chk("post_rst_intreq", cpu_intreq_o, 0);

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 7) == 0) in_eirq_i[$urandom_range(0, 7)] ^= 1'b1;
            if ($urandom_range(0, 39) == 0) in_eirq_i = 8'($urandom);
            in_intreq_err_i = ($urandom_range(0, 9) == 0) ? 1'($urandom) : (in_eirq_i != 0);
            cpu_ack_i = ($urandom_range(0, 5) == 0);
            tmo_clr_i = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 299) == 0) begin
                #2 rst_n = 0;
                model_reset();
                #1 check_all();
                step();
                rst_n = 1;
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/intc_err_req.md
# intc_err_req

Error-interrupt request/acknowledge sequencer, directly downstream of the error interrupt capture stage in the interrupt controller. It takes the capture stage's aggregated request and pending-bit vector, and picks the highest-priority pending error source. It presents a level and vector request to the CPU, and converts the CPU's acceptance into the one-cycle error acknowledge pulse the capture stage consumes to enter its in-service state.

## Interface
Parameters:
- VEC_BASE, 8'h40, vector number of error source 0; source i gets VEC_BASE+i (mod 256)
- ERR_LEVEL, 4'hF, interrupt level presented to the CPU for all error requests
- ACK_TMO, 255, maximum cycles in REQ without CPU acceptance before withdrawal (legal 2..255)

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- in_intreq_err_i  in  1  aggregated error request from capture stage
- in_eirq_i  in  8  pending error bits from capture stage (bit 0 highest priority)
- cpu_intreq_o  out  1  interrupt request to CPU
- cpu_level_o  out  4  request level, valid while cpu_intreq_o
- cpu_vec_o  out  8  request vector, valid while cpu_intreq_o
- cpu_ack_i  in  1  CPU accepts current request (sampled only in REQ)
- cp_intack_err_o  out  1  one-cycle acknowledge pulse to capture stage
- err_srv_o  out  1  an error source is in service
- err_srv_id_o  out  3  index of source requested or in service
- tmo_o  out  1  sticky: a request was withdrawn by timeout
- tmo_clr_i  in  1  clears tmo_o

## Operation
- States: IDLE, REQ, SRV.
- IDLE: if in_intreq_err_i && |in_eirq_i, latch id = lowest set index of in_eirq_i and go to REQ. Otherwise stay in IDLE.
- REQ: cpu_intreq_o=1, cpu_level_o=ERR_LEVEL, cpu_vec_o=VEC_BASE+id. Wait-counter increments every cycle.
  - cpu_ack_i=1: pulse cp_intack_err_o, go to SRV.
  - Else in_eirq_i[id]=0 (cleared or masked): withdraw, go to IDLE with no pulse.
  - Else counter reaches ACK_TMO-1: set tmo_o, go to IDLE.
- SRV: err_srv_o=1. Stay until in_eirq_i[id]=0 (software cleared the source), then go to IDLE.
- Priority of events in REQ: ack > withdraw > timeout.
- id is frozen from the IDLE→REQ transition until the next return to IDLE. Higher-priority arrivals do not preempt a pending request.
- tmo_o: set wins over a simultaneous tmo_clr_i.
- Counter is 8 bits and clears on every entry to REQ. It never wraps, because the timeout fires first.

## Timing
- All outputs are registered.
- Reset values: cpu_intreq_o=0, cpu_level_o=0, cpu_vec_o=0, cp_intack_err_o=0, err_srv_o=0, err_srv_id_o=0, tmo_o=0. State resets to IDLE and the counter to 0.
- Request latency: in_intreq_err_i sampled high at edge N → cpu_intreq_o high from N+1.
- Ack: cpu_ack_i sampled high at edge M → during M+1, cp_intack_err_o=1 for exactly one cycle, cpu_intreq_o=0, err_srv_o=1. The capture stage drops its request at M+2.
- Withdraw and timeout both deassert cpu_intreq_o at the next edge. Re-arbitration is possible from the following edge, so the minimum gap is 1 idle cycle.
- SRV exit: in_eirq_i[id] seen low at edge K → err_srv_o=0 from K+1.
- Reset asserted mid-operation: all outputs return to reset values immediately. No ack pulse is emitted.

## Structure
- Package intc_err_pkg holds:
  - the state enum (IDLE/REQ/SRV, 2-bit encoding)
  - localparam NUM_ERR=8
  - localparam ERR_ID_W=3
  - the counter width (8)
- Sub-module intc_err_prio: 8-to-3 combinational lowest-index priority encoder with valid output, reusable by other interrupt-controller stages.
- Registers use the async active-low reset flop style.

## Test plan
- Single source: in_eirq_i=8'h10, in_intreq_err_i=1 → next cycle cpu_intreq_o=1, cpu_vec_o=8'h44, cpu_level_o=4'hF. Ack → one-cycle cp_intack_err_o, err_srv_id_o=4. Clear bit 4 → err_srv_o=0 next cycle.
- Priority: in_eirq_i=8'hA4 → err_srv_id_o=2, cpu_vec_o=8'h42. Setting bit 0 while in REQ does not change the vector.
- Withdraw: clear in_eirq_i[id] in REQ with no ack → cpu_intreq_o=0 next cycle, no cp_intack_err_o, tmo_o=0.
- Timeout with ACK_TMO=4: no ack → cpu_intreq_o high for exactly 4 cycles, then tmo_o=1. tmo_clr_i clears it. Ack on the same cycle as the timeout → ack pulse and tmo_o stays 0.
- Ack and bit clear on the same cycle → ack wins: cp_intack_err_o=1 and SRV entered, then exit to IDLE one cycle later.
- Assert rst_n low during REQ → cpu_intreq_o=0 with no clock edge required. After release, state is IDLE and there is no stray pulse.
